ad7352_capture: RTL



---
 rtl/ad7352_capture_pkg.sv | 15 +
 rtl/ad7352_capture_if.sv | 30 +++
 rtl/adc_frame_timer.sv | 55 +++++
 rtl/ad7352_capture.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ad7352_capture_pkg.sv
// Shared types and AD7352 frame constants for the channel-A capture front end.
package ad7352_capture_pkg;

  localparam int unsigned SampleWidth  = 12;
  localparam int unsigned DefLeadZeros = 2;
  localparam int unsigned CLK_HZ       = 50_000_000;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StConv,
    StDone
  } cap_state_e;

endpackage

// File: rtl/ad7352_capture_if.sv
// ADC serial lines plus FIFO write port; master is the capture block, slave the ADC/FIFO side.
interface ad7352_capture_if;
  import ad7352_capture_pkg::*;

  logic                   adc_cs_n;
  logic                   adc_sclk;
  logic                   adc_sdata_a;
  logic [SampleWidth-1:0] fifo_data;
  logic                   fifo_wrreq;
  logic                   fifo_full;

  modport master (
    output adc_cs_n,
    output adc_sclk,
    output fifo_data,
    output fifo_wrreq,
    input  adc_sdata_a,
    input  fifo_full
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sclk,
    input  fifo_data,
    input  fifo_wrreq,
    output adc_sdata_a,
    output fifo_full
  );

endinterface

// File: rtl/adc_frame_timer.sv
// Conversion phase counter with registered CS/SCLK waveforms and per-frame strobes.
module adc_frame_timer #(
  parameter int unsigned CONV_PERIOD = 40,
  parameter int unsigned FRAME_SCLKS = 16
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic run_i,
  output logic cs_n_o,
  output logic sclk_o,
  output logic sclk_rise_o,
  output logic wr_slot_o
);

  localparam int unsigned    PhW        = $clog2(CONV_PERIOD);
  localparam logic [PhW-1:0] PhLast     = PhW'(CONV_PERIOD - 1);
  localparam logic [PhW-1:0] PhCsRise   = PhW'(2 * FRAME_SCLKS + 1);
  localparam logic [PhW-1:0] PhSclkLast = PhW'(2 * FRAME_SCLKS - 1);

  logic [PhW-1:0] ph_d, ph_q;
  logic           run_q;
  logic           cs_n_d, cs_n_q;
  logic           sclk_d, sclk_q;

  // Waveforms are decoded from the next phase so the pins line up with ph_q.
  always_comb begin
    ph_d = '0;
    if (run_i && run_q) begin
      ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
    end
    cs_n_d = !run_i || (ph_d >= PhCsRise);
    sclk_d = !(run_i && ph_d[0] && (ph_d <= PhSclkLast));
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= '0;
      run_q  <= 1'b0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b1;
    end else begin
      ph_q   <= ph_d;
      run_q  <= run_i;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
    end
  end

  // SCLK is never low for two cycles, so the clock edge leaving a low cycle is a rise.
  assign sclk_rise_o = ~sclk_q;
  assign wr_slot_o   = run_q & (ph_q == PhCsRise);
  assign cs_n_o      = cs_n_q;
  assign sclk_o      = sclk_q;

endmodule

// File: rtl/ad7352_capture.sv
// AD7352 channel-A capture: arms on a start pulse, runs SAMPLE_COUNT conversions into the FIFO.
module ad7352_capture
  import ad7352_capture_pkg::*;
#(
  parameter int unsigned CONV_PERIOD  = 40,
  parameter int unsigned FRAME_SCLKS  = 16,
  parameter int unsigned LEAD_ZEROS   = DefLeadZeros,
  parameter logic [19:0] SAMPLE_COUNT = 20'd8000,
  parameter int unsigned ARM_CYCLES   = 4
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             sys_start_pulse,
  ad7352_capture_if.master adc_fifo,
  output logic             capture_busy,
  output logic             capture_done,
  output logic             overflow_flag,
  output logic [19:0]      sample_cnt
);

  localparam int unsigned     ArmW    = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ArmW-1:0] ArmLast = ArmW'(ARM_CYCLES - 1);
  // Lead-zero bits fall off the top, so the sample ends up MSB-aligned in the register.
  localparam int unsigned     ShW     = FRAME_SCLKS - LEAD_ZEROS;

  cap_state_e             state_d, state_q;
  logic [ArmW-1:0]        arm_d, arm_q;
  logic [19:0]            cnt_d, cnt_q;
  logic [ShW-1:0]         sh_d, sh_q;
  logic [SampleWidth-1:0] data_d, data_q;
  logic                   wrreq_d, wrreq_q;
  logic                   done_d, done_q;
  logic                   busy_d, busy_q;
  logic                   ovf_d, ovf_q;

  logic conv_run, cs_n, sclk, sclk_rise, wr_slot;

  assign conv_run = (state_d == StConv);

  adc_frame_timer #(
    .CONV_PERIOD(CONV_PERIOD),
    .FRAME_SCLKS(FRAME_SCLKS)
  ) u_timer (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .run_i      (conv_run),
    .cs_n_o     (cs_n),
    .sclk_o     (sclk),
    .sclk_rise_o(sclk_rise),
    .wr_slot_o  (wr_slot)
  );

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    wrreq_d = 1'b0;
    done_d  = 1'b0;
    // Start wins over everything, including a write slot in the same cycle.
    if (sys_start_pulse) begin
      state_d = StArm;
      arm_d   = '0;
      cnt_d   = '0;
      sh_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: state_d = state_q;
        StArm: begin
          if (arm_q == ArmLast) state_d = StConv;
          else                  arm_d   = arm_q + 1'b1;
        end
        StConv: begin
          if (cnt_q >= SAMPLE_COUNT) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            if (sclk_rise) sh_d = {sh_q[ShW-2:0], adc_fifo.adc_sdata_a};
            if (wr_slot) begin
              cnt_d = cnt_q + 20'd1;
              if (!adc_fifo.fifo_full) begin
                wrreq_d = 1'b1;
                data_d  = sh_q[ShW-1 -: SampleWidth];
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d == StArm) || (state_d == StConv);
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      arm_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      wrreq_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      wrreq_q <= wrreq_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign adc_fifo.adc_cs_n   = cs_n;
  assign adc_fifo.adc_sclk   = sclk;
  assign adc_fifo.fifo_data  = data_q;
  assign adc_fifo.fifo_wrreq = wrreq_q;
  assign capture_busy        = busy_q;
  assign capture_done        = done_q;
  assign overflow_flag       = ovf_q;
  assign sample_cnt          = cnt_q;

endmodule
